// File: rtl/led7_scan.sv
// Multiplexed 7-segment display scanner.
// Steps a one-hot digit select across NUM_DIGITS digits, SCAN_DIV clocks per digit slot,
// with GUARD blank cycles at the start of each slot to suppress ghosting. New data is
// staged in a pending register and only moves into the display register at a frame
// boundary, so a frame never shows a mix of old and new digits.
// Optional feature: define LED7_SCAN_LZB_EN for leading-zero blanking.
module led7_scan #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned GUARD      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data,
  input  logic        load,
  output logic [3:0]  digit_code,
  output logic        digit_on,
  output logic [7:0]  digit_sel,
  output logic        frame_start
);

  localparam logic [15:0] CntMax  = 16'(SCAN_DIV - 1);
  localparam logic [2:0]  LastIdx = 3'(NUM_DIGITS - 1);
  localparam logic [16:0] GuardW  = 17'(GUARD);

  // StWait covers the first prescaler period after reset, before slot 0 has begun.
  typedef enum logic {StWait, StScan} phase_e;

  phase_e      phase_q, phase_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] disp_q, disp_d;
  logic [31:0] pend_q, pend_d;
  logic        flag_q, flag_d;
  logic [3:0]  code_q, code_d;
  logic        on_q, on_d;
  logic [7:0]  sel_q, sel_d;
  logic        fs_q, fs_d;

  logic        tick;
  logic        boundary;
  logic        lit;
  logic        blank;

  // Prescaler, slot index and frame-boundary detection.
  always_comb begin
    tick     = (cnt_q == CntMax);
    cnt_d    = tick ? 16'd0 : cnt_q + 16'd1;
    phase_d  = phase_q;
    idx_d    = idx_q;
    boundary = 1'b0;
    if (tick) begin
      if (phase_q == StWait) begin
        // First tick after reset starts slot 0 rather than advancing past it.
        phase_d  = StScan;
        idx_d    = 3'd0;
        boundary = 1'b1;
      end else if (idx_q == LastIdx) begin
        idx_d    = 3'd0;
        boundary = 1'b1;
      end else begin
        idx_d    = idx_q + 3'd1;
      end
    end
  end

  // Double-buffered display data: latest load wins, committed only at a frame boundary.
  always_comb begin
    disp_d = disp_q;
    pend_d = pend_q;
    flag_d = flag_q;
    if (boundary) begin
      flag_d = 1'b0;
      if (load) begin
        disp_d = data;
      end else if (flag_q) begin
        disp_d = pend_q;
      end
    end else if (load) begin
      pend_d = data;
      flag_d = 1'b1;
    end
  end

`ifdef LED7_SCAN_LZB_EN
  logic [7:0] zero_from;
  logic       zero_run;

  // zero_from[k] is set when nibbles k..NUM_DIGITS-1 of the next display value are all zero.
  always_comb begin
    zero_run  = 1'b1;
    zero_from = '0;
    for (int k = 7; k >= 0; k--) begin
      if (k < int'(NUM_DIGITS)) begin
        zero_run = zero_run & (disp_d[4*k +: 4] == 4'd0);
      end
      zero_from[k] = zero_run;
    end
  end

  // Leading zeros go dark; digit 0 always shows.
  always_comb begin
    blank = (idx_d != 3'd0) && zero_from[idx_d];
  end
`else
  // No blanking: every digit shows its nibble.
  always_comb begin
    blank = 1'b0;
  end
`endif

  // Next-cycle output values, derived from the next-cycle state so outputs are registered.
  always_comb begin
    // cnt_d + 1 > GUARD is cnt_d >= GUARD without a constant compare when GUARD is 0.
    lit    = (phase_d == StScan) && (({1'b0, cnt_d} + 17'd1) > GuardW);
    sel_d  = lit ? (8'd1 << idx_d) : 8'd0;
    on_d   = lit && !blank;
    code_d = (phase_d == StScan) ? disp_d[{idx_d, 2'b00} +: 4] : 4'd0;
    fs_d   = boundary;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= StWait;
      cnt_q   <= 16'd0;
      idx_q   <= 3'd0;
      disp_q  <= 32'd0;
      pend_q  <= 32'd0;
      flag_q  <= 1'b0;
      code_q  <= 4'd0;
      on_q    <= 1'b0;
      sel_q   <= 8'd0;
      fs_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      disp_q  <= disp_d;
      pend_q  <= pend_d;
      flag_q  <= flag_d;
      code_q  <= code_d;
      on_q    <= on_d;
      sel_q   <= sel_d;
      fs_q    <= fs_d;
    end
  end

  assign digit_code  = code_q;
  assign digit_on    = on_q;
  assign digit_sel   = sel_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_led7_scan.sv
// Directed bench for led7_scan: a 4-digit instance (SCAN_DIV=4, GUARD=1) and a
// 1-digit instance (SCAN_DIV=4, GUARD=0) sharing clock, reset and load bus.
module tb_led7_scan;

`ifdef LED7_SCAN_LZB_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] data;
  logic        load;

  logic [3:0]  code0, code1;
  logic        on0, on1;
  logic [7:0]  sel0, sel1;
  logic        fs0, fs1;

  int errors = 0;
  int checks = 0;

  led7_scan #(.NUM_DIGITS(4), .SCAN_DIV(4), .GUARD(1)) u_dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .data        (data),
    .load        (load),
    .digit_code  (code0),
    .digit_on    (on0),
    .digit_sel   (sel0),
    .frame_start (fs0)
  );

  led7_scan #(.NUM_DIGITS(1), .SCAN_DIV(4), .GUARD(0)) u_dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .data        (data),
    .load        (load),
    .digit_code  (code1),
    .digit_on    (on1),
    .digit_sel   (sel1),
    .frame_start (fs1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " sel"},   32'(sel0), 32'd0);
    chk({tag, " on"},    32'(on0),  32'd0);
    chk({tag, " code"},  32'(code0), 32'd0);
    chk({tag, " fs"},    32'(fs0),  32'd0);
    chk({tag, " sel1"},  32'(sel1), 32'd0);
    chk({tag, " on1"},   32'(on1),  32'd0);
    chk({tag, " fs1"},   32'(fs1),  32'd0);
  endtask

  // Idle period between reset release and the first slot tick.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_zero("idle");
    end
  endtask

  // Check ncyc cycles of one slot of the 4-digit DUT; optionally drive a load at cycle ld_cyc.
  // With c1 set, the 1-digit DUT (display expected 0) is checked in the same cycles.
  task automatic run_slot(input int idx, input logic [3:0] code, input logic on, input int ncyc,
                          input logic ld_en, input int ld_cyc, input logic [31:0] ld_val,
                          input logic c1);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      chk($sformatf("slot%0d c%0d sel", idx, c), 32'(sel0),
          (c == 0) ? 32'd0 : (32'd1 << idx));
      chk($sformatf("slot%0d c%0d on", idx, c), 32'(on0), (c == 0) ? 32'd0 : 32'(on));
      chk($sformatf("slot%0d c%0d code", idx, c), 32'(code0), 32'(code));
      chk($sformatf("slot%0d c%0d fs", idx, c), 32'(fs0),
          (c == 0 && idx == 0) ? 32'd1 : 32'd0);
      if (c1) begin
        chk($sformatf("u1 c%0d sel", c), 32'(sel1), 32'd1);
        chk($sformatf("u1 c%0d on", c), 32'(on1), 32'd1);
        chk($sformatf("u1 c%0d code", c), 32'(code1), 32'd0);
        chk($sformatf("u1 c%0d fs", c), 32'(fs1), (c == 0) ? 32'd1 : 32'd0);
      end
      load = ld_en && (c == ld_cyc);
      if (load) data = ld_val;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    load  = 1'b0;
    data  = 32'd0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    idle(3);

    // Frame A: display 0; load 4321 mid-frame must not show until frame B.
    run_slot(0, 4'h0, 1'b1,     4, 1'b0, 0, 32'h0, 1'b1);
    run_slot(1, 4'h0, LZ ? 1'b0 : 1'b1, 4, 1'b1, 1, 32'h0000_4321, 1'b1);
    run_slot(2, 4'h0, LZ ? 1'b0 : 1'b1, 4, 1'b0, 0, 32'h0, 1'b0);
    run_slot(3, 4'h0, LZ ? 1'b0 : 1'b1, 4, 1'b0, 0, 32'h0, 1'b0);

    // Frame B: 1,2,3,4; two loads in this frame, latest wins.
    run_slot(0, 4'h1, 1'b1, 4, 1'b1, 1, 32'h0000_1111, 1'b0);
    run_slot(1, 4'h2, 1'b1, 4, 1'b0, 0, 32'h0, 1'b0);
    run_slot(2, 4'h3, 1'b1, 4, 1'b1, 1, 32'h0000_2222, 1'b0);
    run_slot(3, 4'h4, 1'b1, 4, 1'b0, 0, 32'h0, 1'b0);

    // Frame C: 2,2,2,2; load in the boundary cycle (tick of slot 3).
    run_slot(0, 4'h2, 1'b1, 4, 1'b0, 0, 32'h0, 1'b0);
    run_slot(1, 4'h2, 1'b1, 4, 1'b0, 0, 32'h0, 1'b0);
    run_slot(2, 4'h2, 1'b1, 4, 1'b0, 0, 32'h0, 1'b0);
    run_slot(3, 4'h2, 1'b1, 4, 1'b1, 3, 32'h0000_9ABC, 1'b0);

    // Frame D: boundary load shows at once as C,B,A,9.
    run_slot(0, 4'hC, 1'b1, 4, 1'b0, 0, 32'h0, 1'b0);
    run_slot(1, 4'hB, 1'b1, 4, 1'b1, 1, 32'h0000_0050, 1'b0);
    run_slot(2, 4'hA, 1'b1, 4, 1'b0, 0, 32'h0, 1'b0);
    run_slot(3, 4'h9, 1'b1, 4, 1'b0, 0, 32'h0, 1'b0);

    // Frame E: 0050 -> on 1,1,0,0 with blanking; pending load then reset mid slot 2.
    run_slot(0, 4'h0, 1'b1, 4, 1'b0, 0, 32'h0, 1'b0);
    run_slot(1, 4'h5, 1'b1, 4, 1'b0, 0, 32'h0, 1'b0);
    run_slot(2, 4'h0, LZ ? 1'b0 : 1'b1, 3, 1'b1, 1, 32'h0000_7777, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_zero("async reset");
    @(negedge clk);
    chk_zero("in reset");
    rst_n = 1'b1;
    idle(3);

    // Frames F and G: display 0, pending 7777 discarded; 1-digit DUT checked alongside.
    for (int f = 0; f < 2; f++) begin
      run_slot(0, 4'h0, 1'b1,             4, 1'b0, 0, 32'h0, 1'b1);
      run_slot(1, 4'h0, LZ ? 1'b0 : 1'b1, 4, 1'b0, 0, 32'h0, 1'b1);
      run_slot(2, 4'h0, LZ ? 1'b0 : 1'b1, 4, 1'b0, 0, 32'h0, 1'b1);
      run_slot(3, 4'h0, LZ ? 1'b0 : 1'b1, 4, 1'b0, 0, 32'h0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
